// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round controller: holds the state/round-key registers and sequences
// an external combinational round datapath and key-expansion step over 10 rounds.
module aes_round_ctrl #(
  parameter int NROUNDS = 10  // only 10 (AES-128) is meaningful with the rcon table below
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dataout,
  output logic         busy,
  output logic [127:0] cur_state,
  output logic [127:0] cur_key,
  output logic [7:0]   rcon,
  output logic         rnd_last,
  input  logic [127:0] nxt_state,
  input  logic [127:0] nxt_key
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } st_e;

  localparam logic [3:0] LAST = 4'(NROUNDS);

  st_e          st, st_nx;
  logic [3:0]   rnd, rnd_nx;
  logic [127:0] state_reg, key_reg;
  logic         load, adv;

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      rnd       <= 4'd0;
      state_reg <= '0;
      key_reg   <= '0;
    end else begin
      st  <= st_nx;
      rnd <= rnd_nx;
      if (load) begin
        state_reg <= datain ^ key;  // initial AddRoundKey
        key_reg   <= key;
      end else if (adv) begin
        state_reg <= nxt_state;
        key_reg   <= nxt_key;
      end
    end
  end

  always_comb begin
    st_nx     = st;
    rnd_nx    = rnd;
    load      = 1'b0;
    adv       = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rcon      = 8'h00;
    rnd_last  = 1'b0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load   = 1'b1;
          rnd_nx = 4'd1;
          st_nx  = ROUND;
        end
      end
      ROUND: begin
        busy     = 1'b1;
        adv      = 1'b1;
        rcon     = rcon_of(rnd);
        rnd_last = (rnd == LAST);
        // >= so a corrupted counter still terminates instead of wrapping
        if (rnd >= LAST) st_nx = DONE;
        else             rnd_nx = rnd + 4'd1;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) st_nx = IDLE;
      end
      default: begin
        st_nx  = IDLE;
        rnd_nx = 4'd0;
      end
    endcase
  end

  assign dataout   = state_reg;
  assign cur_state = state_reg;
  assign cur_key   = key_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a reference AES round/key datapath attached.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, busy, rnd_last;
  logic [127:0] datain, key, dataout, cur_state, cur_key, nxt_state, nxt_key;
  logic [7:0]   rcon;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NROUNDS(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .datain(datain), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .dataout(dataout), .busy(busy), .cur_state(cur_state), .cur_key(cur_key),
    .rcon(rcon), .rnd_last(rnd_last), .nxt_state(nxt_state), .nxt_key(nxt_key)
  );

  // ---------------- reference AES pieces ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r = 8'h01, base = a;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[0]) r = gmul(r, base);
      base = gmul(base, base);
      e = e >> 1;
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = subword({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic last);
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[r+4*c] = sb[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
      mc[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      mc[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      mc[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      mc[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = last ? sr[i] : mc[i];
    return o ^ k;
  endfunction

  function automatic logic [7:0] rc_tbl(input int i);
    logic [7:0] t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    return t[i];
  endfunction

  function automatic logic [127:0] aesencrypt(input logic [127:0] d, input logic [127:0] k);
    logic [127:0] s = d ^ k, kk = k;
    for (int r = 0; r < 10; r++) begin
      kk = key_step(kk, rc_tbl(r));
      s  = round_fn(s, kk, r == 9);
    end
    return s;
  endfunction

  assign nxt_key   = key_step(cur_key, rcon);
  assign nxt_state = round_fn(cur_state, nxt_key, rnd_last);

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] D2 = 128'haaeabaaeabaaeabaaeabaaeabaaeabaa;
  localparam logic [127:0] K2 = 128'hf1fc7f1fc7f1fc7f1fc7f1fc7f1fc7f1;

  initial begin
    int n;
    logic [127:0] held;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; datain = '0; key = '0;

    // reset state
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rcon", rcon, 0);
    chk("rst_rnd_last", rnd_last, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_cur_state", cur_state, 0);
    chk("rst_cur_key", cur_key, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // block 1: FIPS-197 C.1, with rcon / rnd_last trace
    in_valid = 1'b1; datain = D1; key = K1;
    step();
    in_valid = 1'b0;
    chk("load_state", cur_state, D1 ^ K1);
    chk("load_key", cur_key, K1);
    chk("round_in_ready", in_ready, 0);
    chk("round_busy", busy, 1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("rcon_%0d", i + 1), rcon, rc_tbl(i));
      chk($sformatf("rnd_last_%0d", i + 1), rnd_last, (i == 9));
      chk($sformatf("ov_early_%0d", i + 1), out_valid, 0);
      step();
    end
    chk("lat1_out_valid", out_valid, 1);
    chk("fips_dataout", dataout, C1);
    chk("done_rcon", rcon, 0);

    // hold in DONE; a new block offered meanwhile must be ignored
    held = dataout;
    in_valid = 1'b1; datain = D2; key = K2;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold_ov_%0d", i), out_valid, 1);
      chk($sformatf("hold_data_%0d", i), dataout, held);
      chk($sformatf("hold_ir_%0d", i), in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hs_out_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    chk("hs_busy", busy, 0);
    chk("hs_no_accept", dataout, C1);

    // block 2: accept D2/K2, toggle inputs throughout ROUND
    step();
    chk("b2_load", cur_state, D2 ^ K2);
    n = 0;
    while (!out_valid && n < 20) begin
      datain = {$urandom, $urandom, $urandom, $urandom};
      key    = {$urandom, $urandom, $urandom, $urandom};
      step();
      n++;
    end
    chk("b2_latency", 128'(n), 128'd10);
    chk("b2_dataout", dataout, aesencrypt(D2, K2));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("b2_idle", in_ready, 1);

    // reset during round 5, with in_valid still high
    in_valid = 1'b1; datain = D1; key = K1;
    step();
    in_valid = 1'b0;
    step(); step(); step(); step();
    chk("mid_rcon5", rcon, 8'h10);
    rst = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_rcon", rcon, 0);
    chk("mrst_rnd_last", rnd_last, 0);
    chk("mrst_state", cur_state, 0);
    chk("mrst_key", cur_key, 0);
    chk("mrst_in_ready", in_ready, 1);

    // fresh block after mid-flight reset
    in_valid = 1'b1; datain = D1; key = K1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("b3_latency", 128'(n), 128'd10);
    chk("b3_dataout", dataout, C1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
